// File: rtl/mem_arr_rd_seq_if.sv
// Handshake and lane bus between the read sequencer and its controller / memory array.
// The slave modport is the sequencer side.
interface mem_arr_rd_seq_if #(
  parameter int width_height = 4,
  parameter int ADDR_W       = 8
);
  logic                           start;
  logic [ADDR_W-1:0]              base_addr;
  logic [ADDR_W:0]                num_rows;
  logic                           stall;
  logic [width_height-1:0]        rd_en;
  logic [width_height*ADDR_W-1:0] rd_addr;
  logic [width_height-1:0]        data_valid;
  logic                           busy;
  logic                           done;

  modport master (
    output start, base_addr, num_rows, stall,
    input  rd_en, rd_addr, data_valid, busy, done
  );

  modport slave (
    input  start, base_addr, num_rows, stall,
    output rd_en, rd_addr, data_valid, busy, done
  );
endinterface

// File: rtl/mem_arr_rd_seq.sv
// Diagonally skewed read sequencer for the per-lane input memory array:
// lane i reads row k exactly i issue slots after lane 0 does.
module mem_arr_rd_seq #(
  parameter int width_height = 4,
  parameter int ADDR_W       = 8,
  parameter int RD_LAT       = 1
) (
  input logic             clk,
  input logic             reset,
  mem_arr_rd_seq_if.slave bus
);
  localparam int CNT_W = ADDR_W + 2;
  localparam int FL_W  = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [FL_W-1:0]                fl_q, fl_d;
  logic [ADDR_W-1:0]              base_q, base_d;
  logic [ADDR_W:0]                rows_q, rows_d;
  logic [width_height-1:0]        rd_en_q, rd_en_d;
  logic [width_height*ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           issue;
  logic [CNT_W-1:0]               idx;
  logic [ADDR_W-1:0]              iss_base;
  logic [ADDR_W:0]                iss_rows;

  // Index of the final issue slot; only meaningful for rows >= 1.
  function automatic logic [CNT_W-1:0] last_idx(input logic [ADDR_W:0] rows);
    return CNT_W'(rows) + CNT_W'(width_height) - CNT_W'(2);
  endfunction

  function automatic logic lane_active(input logic [CNT_W-1:0] k, input int lane,
                                       input logic [ADDR_W:0] rows);
    return (k >= CNT_W'(lane)) && (k < CNT_W'(lane) + CNT_W'(rows));
  endfunction

  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0] k, input int lane);
    return base + k[ADDR_W-1:0] - ADDR_W'(lane);
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fl_d     = '0;
    base_d   = base_q;
    rows_d   = rows_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    idx      = cnt_q;
    iss_base = base_q;
    iss_rows = rows_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          busy_d   = 1'b1;
          base_d   = bus.base_addr;
          rows_d   = bus.num_rows;
          cnt_d    = '0;
          idx      = '0;
          iss_base = bus.base_addr;
          iss_rows = bus.num_rows;
          // Nothing is in flight for an empty sequence, so done follows on the next cycle.
          if (bus.num_rows == '0) begin
            state_d = FLUSH;
            fl_d    = FL_W'(RD_LAT);
          end else begin
            state_d = RUN;
            if (!bus.stall) begin
              issue = 1'b1;
              cnt_d = CNT_W'(1);
              if (last_idx(bus.num_rows) == '0) state_d = FLUSH;
            end
          end
        end
      end
      RUN: begin
        if (!bus.stall) begin
          issue = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == last_idx(rows_q)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (fl_q == FL_W'(RD_LAT)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          fl_d = fl_q + FL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Inactive or stalled lanes keep their previous address.
  always_comb begin
    rd_en_d   = '0;
    rd_addr_d = rd_addr_q;
    for (int i = 0; i < width_height; i++) begin
      if (issue && lane_active(idx, i, iss_rows)) begin
        rd_en_d[i]                    = 1'b1;
        rd_addr_d[i*ADDR_W +: ADDR_W] = lane_addr(iss_base, idx, i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fl_q      <= '0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fl_q      <= fl_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
    rows_q <= rows_d;
  end

  // Read-latency alignment of the per-lane valid strobes.
  generate
    if (RD_LAT == 0) begin : g_dv_direct
      assign bus.data_valid = rd_en_q;
    end else begin : g_dv_pipe
      logic [width_height-1:0] dv_q [RD_LAT];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < RD_LAT; k++) dv_q[k] <= '0;
        end else begin
          dv_q[0] <= rd_en_q;
          for (int k = 1; k < RD_LAT; k++) dv_q[k] <= dv_q[k-1];
        end
      end
      assign bus.data_valid = dv_q[RD_LAT-1];
    end
  endgenerate

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_mem_arr_rd_seq.sv
// Bench for mem_arr_rd_seq: directed scenarios plus random traffic, every cycle
// compared against a slot-based reference model of the skewed read schedule.
module tb_mem_arr_rd_seq;
  localparam int W   = 4;
  localparam int AW  = 8;
  localparam int LAT = 1;

  logic clk;
  logic reset;

  mem_arr_rd_seq_if #(.width_height(W), .ADDR_W(AW)) bus ();

  mem_arr_rd_seq #(.width_height(W), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_cnt [W];

  // Reference model: a sequence is a run of issue slots; slot s reads row s-i on lane i.
  int              mode;   // 0 idle, 1 issuing, 2 draining
  int              m_s;
  int              m_n;
  int              m_wait;
  logic [AW-1:0]   m_base;
  logic [W-1:0]    exp_en;
  logic [W-1:0]    exp_dv;
  logic [W*AW-1:0] exp_addr;
  logic            exp_busy;
  logic            exp_done;
  logic [W-1:0]    hist [$];

  function automatic void model_reset();
    mode = 0; m_s = 0; m_n = 0; m_wait = 0; m_base = '0;
    exp_en = '0; exp_dv = '0; exp_addr = '0; exp_busy = 1'b0; exp_done = 1'b0;
    hist.delete();
    for (int j = 0; j < LAT; j++) hist.push_back('0);
  endfunction

  function automatic void model_edge(input logic st, input logic stl,
                                     input logic [AW-1:0] b, input logic [AW:0] n);
    logic [W-1:0] en_n;
    logic         dn;
    int           k;
    en_n = '0;
    dn   = 1'b0;
    hist.push_front(exp_en);
    exp_dv = hist[LAT-1];
    while (hist.size() > LAT) void'(hist.pop_back());
    if (mode == 0) begin
      if (st) begin
        m_base = b;
        m_n    = int'(n);
        m_s    = 0;
        if (m_n == 0) begin
          mode   = 2;
          m_wait = 0;
        end else begin
          mode = 1;
        end
      end
    end else if (mode == 2) begin
      if (m_wait == 0) begin
        dn   = 1'b1;
        mode = 0;
      end else begin
        m_wait--;
      end
    end
    if (mode == 1 && !stl) begin
      for (int i = 0; i < W; i++) begin
        k = m_s - i;
        if (k >= 0 && k < m_n) begin
          en_n[i]               = 1'b1;
          exp_addr[i*AW +: AW] = m_base + AW'(k);
        end
      end
      m_s++;
      if (m_s == m_n + W - 1) begin
        mode   = 2;
        m_wait = LAT;
      end
    end
    exp_en   = en_n;
    exp_done = dn;
    exp_busy = (mode != 0) || dn;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic stl, input logic [AW-1:0] b, input logic [AW:0] n);
    bus.start     = st;
    bus.stall     = stl;
    bus.base_addr = b;
    bus.num_rows  = n;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(bus.start, bus.stall, bus.base_addr, bus.num_rows);
    cyc++;
    #1;
    chk("rd_en", 64'(bus.rd_en), 64'(exp_en));
    chk("rd_addr", 64'(bus.rd_addr), 64'(exp_addr));
    chk("data_valid", 64'(bus.data_valid), 64'(exp_dv));
    chk("busy", 64'(bus.busy), 64'(exp_busy));
    chk("done", 64'(bus.done), 64'(exp_done));
    for (int i = 0; i < W; i++) rd_cnt[i] += int'(bus.rd_en[i]);
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] n, output int t0);
    for (int i = 0; i < W; i++) rd_cnt[i] = 0;
    t0 = cyc;
    drive(1'b1, 1'b0, b, n);
    tick();
    drive(1'b0, 1'b0, b, n);
  endtask

  task automatic wait_done(input string tag, input int n, input int t0, input int exp_lat);
    int lim;
    lim = 0;
    while (bus.done !== 1'b1 && lim < 600) begin
      tick();
      lim++;
    end
    chk({tag, "_done_cycle"}, 64'(cyc - t0), 64'(exp_lat));
    for (int i = 0; i < W; i++) chk({tag, "_lane_reads"}, 64'(rd_cnt[i]), 64'(n));
  endtask

  initial begin
    int t0;
    int t1;
    int lim;
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    model_reset();
    tick();
    tick();
    chk("reset_rd_en", 64'(bus.rd_en), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    #2 reset = 1'b0;
    tick();

    // Basic skew and timing.
    launch(8'h10, 9'd3, t0);
    wait_done("basic", 3, t0, 8);
    chk("basic_busy_at_done", 64'(bus.busy), 64'd1);
    tick();
    chk("basic_busy_after", 64'(bus.busy), 64'd0);

    // Address wrap.
    launch(8'hFE, 9'd4, t0);
    wait_done("wrap", 4, t0, 9);
    tick();

    // Two-cycle stall; skew and addresses preserved.
    launch(8'h40, 9'd3, t0);
    tick();
    drive(1'b0, 1'b1, 8'h40, 9'd3);
    tick();
    chk("stall_rd_en", 64'(bus.rd_en), 64'd0);
    chk("stall_addr_lane0", 64'(bus.rd_addr[7:0]), 64'h41);
    chk("stall_addr_lane1", 64'(bus.rd_addr[15:8]), 64'h40);
    tick();
    drive(1'b0, 1'b0, 8'h40, 9'd3);
    wait_done("stall", 3, t0, 10);
    tick();

    // Empty sequence.
    launch(8'h55, 9'd0, t0);
    wait_done("empty", 0, t0, 2);
    tick();

    // Start while busy is dropped.
    launch(8'h20, 9'd5, t0);
    tick();
    drive(1'b1, 1'b0, 8'h99, 9'd2);
    tick();
    drive(1'b0, 1'b0, 8'h00, 9'd0);
    wait_done("busy_start", 5, t0, 10);
    tick();

    // Start coincident with done.
    launch(8'h30, 9'd2, t0);
    wait_done("coinc_first", 2, t0, 7);
    launch(8'h50, 9'd3, t1);
    chk("coinc_rd_en", 64'(bus.rd_en), 64'h1);
    chk("coinc_addr_lane0", 64'(bus.rd_addr[7:0]), 64'h50);
    wait_done("coinc_second", 3, t1, 8);
    tick();

    // Full 256-row sequence.
    launch(8'h00, 9'd256, t0);
    wait_done("full", 256, t0, 261);
    tick();

    // Asynchronous reset in the middle of issuing.
    launch(8'h70, 9'd5, t0);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("areset_rd_en", 64'(bus.rd_en), 64'd0);
    chk("areset_rd_addr", 64'(bus.rd_addr), 64'd0);
    chk("areset_data_valid", 64'(bus.data_valid), 64'd0);
    chk("areset_busy", 64'(bus.busy), 64'd0);
    chk("areset_done", 64'(bus.done), 64'd0);
    tick();
    #2 reset = 1'b0;
    repeat (4) tick();

    // Random traffic.
    for (int r = 0; r < 500; r++) begin
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            AW'($urandom), (AW+1)'($urandom_range(0, 9)));
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    lim = 0;
    while ((mode != 0 || exp_busy) && lim < 60) begin
      tick();
      lim++;
    end
    tick();
    chk("drain_idle", 64'(bus.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
